prog_timer: RTL and testbench

PROG_TIMER -- requirements
Module: prog_timer

---
 rtl/prog_timer.sv | 95 +++++++++
 tb/tb_prog_timer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/prog_timer.sv
// Programmable down-counting timer with a clock prescaler and one-cycle expire pulse.
// Periodic (auto-reload) mode is built only when PROG_TIMER_AUTORELOAD_EN is defined.
module prog_timer #(
  parameter int              WIDTH          = 4,
  parameter longint unsigned PRESCALE       = 100_000_000,
  parameter int              PRESCALE_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             expired,
  output logic             running
);

  localparam logic [PRESCALE_WIDTH-1:0] PRESC_MAX = PRESCALE_WIDTH'(PRESCALE - 1);

  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]          count_q, count_d;
  logic                      expired_q, expired_d;
  logic [WIDTH-1:0]          reload_val;
  logic                      tick;

`ifdef PROG_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_val_q, reload_val_d;
  logic             reload_sel;

  assign reload_val = reload_val_q;
  assign reload_sel = auto_reload;
`else
  logic unused_auto_reload;

  assign unused_auto_reload = auto_reload;
  assign reload_val         = '0;
`endif

  assign tick = en && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    expired_d = 1'b0;
`ifdef PROG_TIMER_AUTORELOAD_EN
    reload_val_d = reload_val_q;
`endif
    if (load) begin
      presc_d = '0;
      count_d = init;
`ifdef PROG_TIMER_AUTORELOAD_EN
      reload_val_d = init;
`endif
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      // A zero count never expires, so a periodic timer loaded with 0 stays idle.
      if (tick) begin
        if (count_q > WIDTH'(1)) begin
          count_d = count_q - 1'b1;
        end else if (count_q == WIDTH'(1)) begin
          expired_d = 1'b1;
`ifdef PROG_TIMER_AUTORELOAD_EN
          count_d = reload_sel ? reload_val : '0;
`else
          count_d = reload_val;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      presc_q   <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
`ifdef PROG_TIMER_AUTORELOAD_EN
      reload_val_q <= '0;
`endif
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      expired_q <= expired_d;
`ifdef PROG_TIMER_AUTORELOAD_EN
      reload_val_q <= reload_val_d;
`endif
    end
  end

  assign out     = count_q;
  assign expired = expired_q;
  assign running = (count_q != '0) && en;

endmodule

// File: tb/tb_prog_timer.sv
// Directed self-checking bench for prog_timer at WIDTH=4, PRESCALE=4.
module tb_prog_timer;

  logic       clk;
  logic       rstb;
  logic       en;
  logic       load;
  logic [3:0] init;
  logic       auto_reload;
  logic [3:0] out;
  logic       expired;
  logic       running;

  int passed = 0;
  int total  = 0;

  prog_timer #(.WIDTH(4), .PRESCALE(4), .PRESCALE_WIDTH(32)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .en          (en),
    .load        (load),
    .init        (init),
    .auto_reload (auto_reload),
    .out         (out),
    .expired     (expired),
    .running     (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e_out;
    int         pulses;

    rstb = 1'b0; en = 1'b0; load = 1'b0; init = '0; auto_reload = 1'b0;
    #3;
    chk("rst_out", out, 0);
    chk("rst_expired", expired, 0);
    chk("rst_running", running, 0);
    clks(2);
    rstb = 1'b1;
    en   = 1'b1;
    clks(3);
    chk("idle_out", out, 0);
    chk("idle_running", running, 0);

    // One-shot: init=3
    init = 4'd3; load = 1'b1;
    clks(1);
    load = 1'b0;
    chk("os_out0", out, 3);
    chk("os_running0", running, 1);
    for (int k = 1; k <= 14; k++) begin
      clks(1);
      e_out = (k < 4) ? 4'd3 : (k < 8) ? 4'd2 : (k < 12) ? 4'd1 : 4'd0;
      chk($sformatf("os_out_k%0d", k), out, e_out);
      chk($sformatf("os_exp_k%0d", k), expired, (k == 12) ? 1 : 0);
    end

`ifdef PROG_TIMER_AUTORELOAD_EN
    // Periodic: init=2
    init = 4'd2; auto_reload = 1'b1; load = 1'b1;
    clks(1);
    load = 1'b0;
    chk("per_out0", out, 2);
    for (int k = 1; k <= 20; k++) begin
      clks(1);
      chk($sformatf("per_out_k%0d", k), out, ((k % 8) < 4) ? 2 : 1);
      chk($sformatf("per_exp_k%0d", k), expired, ((k % 8) == 0) ? 1 : 0);
    end
`else
    // One-shot only build: auto_reload ignored
    init = 4'd2; auto_reload = 1'b1; load = 1'b1;
    clks(1);
    load = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      clks(1);
      if (expired === 1'b1) pulses++;
      chk($sformatf("noar_out_k%0d", k), out, (k < 4) ? 2 : (k < 8) ? 1 : 0);
      chk($sformatf("noar_exp_k%0d", k), expired, (k == 8) ? 1 : 0);
    end
    chk("noar_pulses", pulses, 1);
`endif

    // Periodic mode loaded with 0 stays idle, no pulse
    init = 4'd0; auto_reload = 1'b1; load = 1'b1;
    clks(1);
    load = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      clks(1);
      if (expired === 1'b1) pulses++;
    end
    chk("zero_out", out, 0);
    chk("zero_running", running, 0);
    chk("zero_pulses", pulses, 0);

    // Enable freeze at presc=2
    auto_reload = 1'b0; init = 4'd3; load = 1'b1;
    clks(1);
    load = 1'b0;
    clks(2);
    chk("frz_presc_pre", dut.presc_q, 2);
    en = 1'b0;
    clks(10);
    chk("frz_out", out, 3);
    chk("frz_presc", dut.presc_q, 2);
    chk("frz_running", running, 0);
    chk("frz_expired", expired, 0);
    en = 1'b1;
    clks(1);
    chk("frz_resume1", out, 3);
    clks(1);
    chk("frz_resume2", out, 2);
    clks(7);
    chk("frz_out21", out, 1);
    chk("frz_exp21", expired, 0);
    clks(1);
    chk("frz_out22", out, 0);
    chk("frz_exp22", expired, 1);
    clks(1);
    chk("frz_exp23", expired, 0);

    // Load overrides a count==1 tick
    init = 4'd1; load = 1'b1;
    clks(1);
    load = 1'b0;
    clks(3);
    chk("ovr_presc_pre", dut.presc_q, 3);
    chk("ovr_out_pre", out, 1);
    init = 4'd9; load = 1'b1;
    clks(1);
    load = 1'b0;
    chk("ovr_out", out, 9);
    chk("ovr_presc", dut.presc_q, 0);
    chk("ovr_expired", expired, 0);
    clks(1);
    chk("ovr_expired2", expired, 0);

    // Asynchronous reset mid-count
    init = 4'd5; load = 1'b1;
    clks(1);
    load = 1'b0;
    clks(2);
    chk("arst_pre", out, 5);
    rstb = 1'b0;
    #1;
    chk("arst_out", out, 0);
    chk("arst_expired", expired, 0);
    chk("arst_running", running, 0);
    chk("arst_presc", dut.presc_q, 0);
    clks(1);
    rstb = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      clks(1);
      if (expired === 1'b1) pulses++;
    end
    chk("arst_idle_out", out, 0);
    chk("arst_idle_pulses", pulses, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
